irq_controller: RTL and testbench
=================================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter: NSRC, 4, number of interrupt sources (2..8).
REQ-002 Parameter: N, 64, data-memory bus width.
REQ-003 Parameter: MASK_ADDR, 64'h7F8, byte address of the memory-mapped mask register.
REQ-004 Port: clk  input  1  single clock; every flop SHALL sit in this domain.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: irq_src  input  NSRC  interrupt lines; a rising edge raises a request.
REQ-007 Port: DM_addr  input  N  processor data-memory address.
REQ-008 Port: DM_writeData  input  N  processor store data.
REQ-009 Port: DM_writeEnable  input  1  processor store strobe.
REQ-010 Port: ExtIAck  input  1  acknowledge from the processor.
REQ-011 Port: ExtIRQ  output  1  interrupt request to the processor.
REQ-012 Port: irq_id  output  $clog2(NSRC)  index of the source being requested; valid while ExtIRQ=1.
REQ-013 Port: pending  output  NSRC  pending-request register, for observation.

Function
REQ-014 Edge detect: pending[i] SHALL be set at edge k when irq_src[i]=1 at edge k and the registered previous sample is 0.
REQ-015 Mask write: at any edge where DM_writeEnable=1 and DM_addr==MASK_ADDR, mask SHALL load DM_writeData[NSRC-1:0]; other addresses SHALL be ignored.
REQ-016 Eligibility: eligible = pending & mask; the lowest eligible index SHALL win.
REQ-017 FSM states: IDLE, REQ, HOLD.
REQ-018 IDLE: when eligible!=0, latch the winner into irq_id and go to REQ; ExtIRQ SHALL rise at the next edge (1 cycle after pending sets).
REQ-019 REQ: ExtIRQ=1 and irq_id SHALL be held stable; on ExtIAck=1, clear pending[irq_id], drop ExtIRQ, and go to HOLD.
REQ-020 HOLD: ExtIRQ=0; when ExtIAck=0, go to IDLE (four-phase handshake).
REQ-021 ExtIAck=1 in IDLE SHALL be ignored.
REQ-022 Masking a source while in REQ SHALL NOT withdraw the active request.
REQ-023 A new edge on source i in the same cycle pending[i] is cleared SHALL leave pending[i]=1 (set wins).
REQ-024 Repeated edges while pending[i]=1 SHALL coalesce into one request.
REQ-025 All NSRC sources pending with all unmasked SHALL be served in index order, one handshake each.

Reset
REQ-026 When reset is asserted: state=IDLE, ExtIRQ=0, irq_id=0, pending=0, mask=all ones, edge samples=0.
REQ-027 Reset during REQ or HOLD SHALL drop ExtIRQ immediately (asynchronously), and the pending request SHALL be lost.

Configuration
REQ-028 Macro IRQ_SYNC_EN.
- Defined: irq_src passes through a two-flop synchronizer before edge detection; latency grows by 2 cycles.
- Undefined: irq_src feeds edge detection directly, with no synchronizer.

Structure
REQ-029 Package irq_pkg SHALL hold the state enum (IDLE/REQ/HOLD) and the MASK_ADDR default.
REQ-030 Sub-module irq_prio_enc: combinational lowest-index priority encoder producing {valid, id}.

Verification
REQ-031 irq_src[2] rises with default mask, IRQ_SYNC_EN undefined:
- pending=4'b0100 after one edge.
- ExtIRQ=1 and irq_id=2 one edge later.
- ExtIAck pulse high then low -> pending=0, ExtIRQ=0.
REQ-032 irq_src=4'b1010 in the same cycle -> irq_id=1 first, then irq_id=3 after the first handshake completes.
REQ-033 Store 64'h1 to 64'h7F8, then raise irq_src[3] -> pending[3]=1 and ExtIRQ stays 0; store 64'hF -> ExtIRQ=1, irq_id=3.
REQ-034 Store 64'h0 to 64'h7F0 -> mask unchanged (4'hF).
REQ-035 New rising edge on irq_src[0] in the same cycle ExtIAck clears pending[0] -> pending[0]=1 and a second request follows.
REQ-036 Assert reset while in REQ -> ExtIRQ=0 before the next clock edge; pending=0 and mask=4'hF after reset.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt controller.
// Optional feature macro: IRQ_SYNC_EN (two-flop input synchronizer).
package irq_pkg;

    // Request handshake phases: waiting for work, request raised, waiting for ack release.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } irq_state_e;

    // Byte address at which the processor stores the source mask.
    localparam logic [63:0] MASK_ADDR_DEFAULT = 64'h7F8;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: reports whether any request is
// present and the index of the lowest-numbered one.
module irq_prio_enc #(
    parameter int NSRC = 4,
    parameter int IDW  = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] req,
    output logic            valid,
    output logic [IDW-1:0]  id
);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        valid = |req;
        id    = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller with a memory-mapped mask and a
// four-phase ExtIRQ/ExtIAck handshake towards the processor.
// Optional feature macro: IRQ_SYNC_EN adds a two-flop synchronizer on irq_src.
//
// Handshake: ExtIRQ rises with irq_id valid and stays stable until the
// processor raises ExtIAck; the served pending bit is cleared on that edge
// and ExtIRQ drops, and no new request is raised until ExtIAck returns low.
module irq_controller
    import irq_pkg::*;
#(
    parameter int            NSRC      = 4,
    parameter int            N         = 64,
    parameter logic [N-1:0]  MASK_ADDR = N'(MASK_ADDR_DEFAULT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NSRC-1:0]         irq_src,
    input  logic [N-1:0]            DM_addr,
    input  logic [N-1:0]            DM_writeData,
    input  logic                    DM_writeEnable,
    input  logic                    ExtIAck,
    output logic                    ExtIRQ,
    output logic [$clog2(NSRC)-1:0] irq_id,
    output logic [NSRC-1:0]         pending
);

    localparam int IDW = $clog2(NSRC);

    irq_state_e      state;
    irq_state_e      next_state;
    logic [NSRC-1:0] src_in;
    logic [NSRC-1:0] prev_q;
    logic [NSRC-1:0] pending_q;
    logic [NSRC-1:0] mask_q;
    logic [IDW-1:0]  id_q;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] clr;
    logic            win_valid;
    logic [IDW-1:0]  win_id;
    logic            latch_id;
    logic            mask_we;
    logic            ext_irq;
    logic            unused_wdata;

    // Only the low NSRC bits of a mask store are meaningful.
    assign unused_wdata = ^DM_writeData[N-1:NSRC];

`ifdef IRQ_SYNC_EN
    logic [NSRC-1:0] sync1_q;
    logic [NSRC-1:0] sync2_q;

    // Two-flop synchronizer for asynchronous interrupt lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_in = sync2_q;
`else
    assign src_in = irq_src;
`endif

    assign rise     = src_in & ~prev_q;
    assign eligible = pending_q & mask_q;
    assign mask_we  = DM_writeEnable && (DM_addr == MASK_ADDR);

    irq_prio_enc #(
        .NSRC (NSRC),
        .IDW  (IDW)
    ) u_prio (
        .req   (eligible),
        .valid (win_valid),
        .id    (win_id)
    );

    // Handshake sequencing: pick a winner in IDLE, hold it in REQ, wait for ack release in HOLD.
    always_comb begin
        next_state = state;
        latch_id   = 1'b0;
        clr        = '0;
        ext_irq    = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    latch_id   = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                ext_irq = 1'b1;
                if (ExtIAck) begin
                    clr[id_q]  = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (!ExtIAck) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State, edge sample, pending, mask and latched winner; a new edge beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            id_q      <= '0;
        end else begin
            state     <= next_state;
            prev_q    <= src_in;
            pending_q <= (pending_q & ~clr) | rise;
            if (mask_we) begin
                mask_q <= DM_writeData[NSRC-1:0];
            end
            if (latch_id) begin
                id_q <= win_id;
            end
        end
    end

    // ExtIRQ is decoded from state so reset withdraws it without waiting for a clock.
    assign ExtIRQ  = ext_irq;
    assign irq_id  = id_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with a cycle-level behavioural model
// checked on every falling edge, plus hand-computed literal checks.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  irq_src = '0;
    logic [63:0] DM_addr = '0;
    logic [63:0] DM_writeData = '0;
    logic        DM_writeEnable = 1'b0;
    logic        ExtIAck = 1'b0;
    logic        ExtIRQ;
    logic [1:0]  irq_id;
    logic [3:0]  pending;

`ifdef IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    irq_controller dut (
        .clk            (clk),
        .reset          (reset),
        .irq_src        (irq_src),
        .DM_addr        (DM_addr),
        .DM_writeData   (DM_writeData),
        .DM_writeEnable (DM_writeEnable),
        .ExtIAck        (ExtIAck),
        .ExtIRQ         (ExtIRQ),
        .irq_id         (irq_id),
        .pending        (pending)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Scoreboard helper
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the processor should see, one step per clock.
    logic [3:0] m_prev = '0, m_s1 = '0, m_s2 = '0, m_pending = '0, m_mask = 4'hF;
    int         m_id = 0;
    bit         m_irq = 1'b0;
    bit         m_wait = 1'b0;

    always @(posedge clk or posedge reset) begin
        logic [3:0] src_eff, rise, clr, elig;
        bit found;
        if (reset) begin
            m_prev = '0; m_s1 = '0; m_s2 = '0;
            m_pending = '0; m_mask = 4'hF;
            m_id = 0; m_irq = 1'b0; m_wait = 1'b0;
        end else begin
`ifdef IRQ_SYNC_EN
            src_eff = m_s2;
            m_s2 = m_s1;
            m_s1 = irq_src;
`else
            src_eff = irq_src;
`endif
            rise = src_eff & ~m_prev;
            m_prev = src_eff;
            clr = '0;
            elig = m_pending & m_mask;
            if (m_irq) begin
                if (ExtIAck) begin
                    clr[m_id] = 1'b1;
                    m_irq = 1'b0;
                    m_wait = 1'b1;
                end
            end else if (m_wait) begin
                if (!ExtIAck) m_wait = 1'b0;
            end else if (elig != 0) begin
                found = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (elig[i] && !found) begin
                        m_id = i;
                        found = 1'b1;
                    end
                end
                m_irq = 1'b1;
            end
            if (DM_writeEnable && DM_addr == 64'h7F8) m_mask = DM_writeData[3:0];
            m_pending = (m_pending & ~clr) | rise;
        end
    end

    // Compare process: DUT against model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_extirq", {31'd0, ExtIRQ}, {31'd0, m_irq});
            check("model_pending", {28'd0, pending}, {28'd0, m_pending});
            if (m_irq) check("model_irq_id", {30'd0, irq_id}, m_id);
        end
    end

    // Driver tasks
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic store(input logic [63:0] addr, input logic [63:0] data);
        DM_addr = addr;
        DM_writeData = data;
        DM_writeEnable = 1'b1;
        tick();
        DM_writeEnable = 1'b0;
    endtask

    task automatic wait_irq(input string name, input int max);
        int n = 0;
        while (!ExtIRQ && n < max) begin
            tick();
            n++;
        end
        check(name, {31'd0, ExtIRQ}, 32'd1);
    endtask

    task automatic handshake();
        ExtIAck = 1'b1;
        tick();
        ExtIAck = 1'b0;
        tick();
    endtask

    initial begin
        cmp_en = 1'b1;
        tick(2);
        reset = 1'b0;
        tick();
        check("reset_pending", {28'd0, pending}, 32'h0);
        check("reset_extirq", {31'd0, ExtIRQ}, 32'd0);
        check("reset_irq_id", {30'd0, irq_id}, 32'd0);

        // Single source, default mask
        irq_src = 4'b0100;
        tick(1 + SYNC_LAT);
        check("single_pending", {28'd0, pending}, 32'h4);
        check("single_extirq_early", {31'd0, ExtIRQ}, 32'd0);
        tick();
        check("single_extirq", {31'd0, ExtIRQ}, 32'd1);
        check("single_id", {30'd0, irq_id}, 32'd2);
        ExtIAck = 1'b1;
        tick();
        check("single_ack_pending", {28'd0, pending}, 32'h0);
        check("single_ack_extirq", {31'd0, ExtIRQ}, 32'd0);
        ExtIAck = 1'b0;
        irq_src = 4'b0000;
        tick(2 + SYNC_LAT);

        // Ack while idle is ignored
        ExtIAck = 1'b1;
        tick();
        ExtIAck = 1'b0;
        tick();
        check("idle_ack_extirq", {31'd0, ExtIRQ}, 32'd0);

        // Two simultaneous sources served lowest first
        irq_src = 4'b1010;
        tick(1 + SYNC_LAT);
        check("dual_pending", {28'd0, pending}, 32'hA);
        tick();
        check("dual_first_id", {30'd0, irq_id}, 32'd1);
        ExtIAck = 1'b1;
        tick();
        check("dual_after_ack", {28'd0, pending}, 32'h8);
        ExtIAck = 1'b0;
        tick(2);
        check("dual_second_irq", {31'd0, ExtIRQ}, 32'd1);
        check("dual_second_id", {30'd0, irq_id}, 32'd3);
        handshake();
        irq_src = 4'b0000;
        tick(2 + SYNC_LAT);

        // Masked source stays pending until unmasked
        store(64'h7F8, 64'h1);
        irq_src = 4'b1000;
        tick(1 + SYNC_LAT);
        check("masked_pending", {28'd0, pending}, 32'h8);
        tick(2);
        check("masked_no_irq", {31'd0, ExtIRQ}, 32'd0);
        store(64'h7F8, 64'hF);
        tick();
        check("unmask_irq", {31'd0, ExtIRQ}, 32'd1);
        check("unmask_id", {30'd0, irq_id}, 32'd3);
        store(64'h7F8, 64'h0);
        check("mask_in_req_holds", {31'd0, ExtIRQ}, 32'd1);
        check("mask_in_req_id", {30'd0, irq_id}, 32'd3);
        handshake();
        store(64'h7F8, 64'hF);
        irq_src = 4'b0000;
        tick(2 + SYNC_LAT);

        // Store to another address leaves mask all ones
        store(64'h7F0, 64'h0);
        irq_src = 4'b0001;
        tick(1 + SYNC_LAT);
        wait_irq("other_addr_irq", 4);
        check("other_addr_id", {30'd0, irq_id}, 32'd0);

        // New edge in the same cycle as the clear: set wins
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b0001;
        tick(SYNC_LAT);
        ExtIAck = 1'b1;
        tick();
        check("setwins_pending", {28'd0, pending}, 32'h1);
        check("setwins_extirq", {31'd0, ExtIRQ}, 32'd0);
        ExtIAck = 1'b0;
        tick();
        wait_irq("setwins_second_irq", 3);
        check("setwins_second_id", {30'd0, irq_id}, 32'd0);
        handshake();
        irq_src = 4'b0000;
        tick(2 + SYNC_LAT);

        // All sources pending, served in index order
        irq_src = 4'b1111;
        tick(1 + SYNC_LAT);
        check("all_pending", {28'd0, pending}, 32'hF);
        for (int i = 0; i < 4; i++) begin
            wait_irq("all_irq", 4);
            check("all_order_id", {30'd0, irq_id}, i);
            handshake();
        end
        check("all_done_pending", {28'd0, pending}, 32'h0);
        irq_src = 4'b0000;
        tick(2 + SYNC_LAT);

        // Reset in the middle of a request
        irq_src = 4'b0010;
        tick(1 + SYNC_LAT);
        wait_irq("rst_setup_irq", 4);
        store(64'h7F8, 64'h0);
        #1 reset = 1'b1;
        irq_src = 4'b0000;
        #1;
        check("rst_async_extirq", {31'd0, ExtIRQ}, 32'd0);
        check("rst_async_pending", {28'd0, pending}, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        irq_src = 4'b0001;
        tick(1 + SYNC_LAT);
        wait_irq("rst_mask_restored", 3);
        check("rst_mask_id", {30'd0, irq_id}, 32'd0);
        handshake();
        irq_src = 4'b0000;
        tick(2 + SYNC_LAT);

        // Random traffic against the model
        for (int c = 0; c < 300; c++) begin
            irq_src = 4'($urandom_range(0, 15));
            ExtIAck = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                DM_addr = ($urandom_range(0, 1) == 1) ? 64'h7F8 : 64'h7F0;
                DM_writeData = 64'($urandom_range(0, 15));
                DM_writeEnable = 1'b1;
            end else begin
                DM_writeEnable = 1'b0;
            end
            tick();
        end
        DM_writeEnable = 1'b0;
        ExtIAck = 1'b0;
        tick(2);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

endmodule
